// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: FSM state encoding and the
// ALU op codes that route an instruction through the multi-cycle MUL/DIV unit.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MD_WAIT = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5
  } state_t;

  localparam logic [3:0] ALU_MUL = 4'b1100;
  localparam logic [3:0] ALU_DIV = 4'b1101;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional MUL/DIV
// wait or data memory access, then write-back with retired-instruction count.
module core_sequencer
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        dec_reg_write,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  input  logic        dec_is_branch,
  input  logic [3:0]  dec_alu_ops,
  input  logic        branch_taken,
  output logic        md_start,
  input  logic        md_done,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [2:0]  state_o,
  output logic [31:0] instret
);

  state_t      state_reg;
  logic [31:0] instret_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      instret_reg <= '0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (imem_ack) state_reg <= ST_DECODE;
        end
        ST_DECODE: begin
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          // A branch never launches MUL/DIV, whatever its ALU field says.
          if (is_muldiv(dec_alu_ops) && !dec_is_branch)
            state_reg <= ST_MD_WAIT;
          else if (dec_mem_read || dec_mem_write)
            state_reg <= ST_MEM;
          else
            state_reg <= ST_WB;
        end
        ST_MD_WAIT: begin
          if (md_done) state_reg <= ST_WB;
        end
        ST_MEM: begin
          if (dmem_ack) state_reg <= ST_WB;
        end
        ST_WB: begin
          state_reg   <= ST_FETCH;
          instret_reg <= instret_reg + 32'd1;
        end
        default: begin
          state_reg <= ST_FETCH;
        end
      endcase
    end
  end

  // Outputs decode the current state; reset masks them so nothing leaks while rst is high.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    md_start = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        ST_EXEC: begin
          md_start = is_muldiv(dec_alu_ops) && !dec_is_branch;
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = dec_mem_write;
        end
        ST_WB: begin
          pc_we  = 1'b1;
          rf_we  = dec_reg_write && !dec_mem_write && !dec_is_branch;
          pc_sel = dec_is_branch && branch_taken;
        end
        default: begin
        end
      endcase
    end
  end

  assign state_o = state_reg;
  assign instret = instret_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized scoreboard bench for core_sequencer: a stimulus process pushes the
// expected per-instruction outcome, a negedge monitor pops it at each write-back.
module tb_core_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, ir_we;
  logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_is_branch;
  logic [3:0]  dec_alu_ops;
  logic        branch_taken;
  logic        md_start, md_done;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        rf_we, pc_we, pc_sel;
  logic [2:0]  state_o;
  logic [31:0] instret;

  core_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_is_branch(dec_is_branch),
    .dec_alu_ops(dec_alu_ops), .branch_taken(branch_taken),
    .md_start(md_start), .md_done(md_done),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .state_o(state_o), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned lat;
    logic        rf_we;
    logic        pc_sel;
    logic        dmem_we;
    int unsigned mem_cycles;
    int unsigned md_pulses;
    logic [31:0] instret;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cur_a = 0, cur_d = 0, cur_k = 1;
  bit          stray_en = 1'b0;
  logic [31:0] model_ir = '0;
  logic        rst_seen = 1'b1;

  always @(posedge clk) rst_seen <= rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference outcome of one instruction, from the sequencing rules alone.
  function automatic exp_t model(input logic [3:0] op, input logic rw, rd, wr, br, tk,
                                 input int unsigned a, d, k, input logic [31:0] ir_after);
    exp_t e;
    bit md, mem;
    md  = ((op == 4'b1100) || (op == 4'b1101)) && !br;
    mem = !md && (rd || wr);
    e.lat        = 4 + a + (md ? k : (mem ? d + 1 : 0));
    e.rf_we      = rw && !wr && !br;
    e.pc_sel     = br && tk;
    e.dmem_we    = wr;
    e.mem_cycles = mem ? d + 1 : 0;
    e.md_pulses  = md ? 1 : 0;
    e.instret    = ir_after;
    return e;
  endfunction

  // Memory / MUL-DIV responder: acks after a programmed number of wait cycles.
  initial begin : responder
    int unsigned icnt, dcnt, mcnt;
    bit md_pend;
    icnt = 0; dcnt = 0; mcnt = 0; md_pend = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; md_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        icnt = 0; dcnt = 0; md_pend = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; md_done = 1'b0;
      end else begin
        imem_ack = imem_req && (icnt == cur_a);
        icnt     = imem_req ? icnt + 1 : 0;
        dmem_ack = dmem_req && (dcnt == cur_d);
        dcnt     = dmem_req ? dcnt + 1 : 0;
        if (md_pend) begin
          mcnt++;
          md_done = (mcnt == cur_k);
          if (md_done) md_pend = 1'b0;
        end else begin
          md_done = stray_en && (imem_req || ($urandom_range(0, 3) == 0));
        end
        if (md_start) begin
          md_pend = 1'b1;
          mcnt    = 0;
        end
      end
    end
  end

  initial begin : monitor
    int unsigned cyc, mem_cyc, md_cnt, irwe_cnt, rf_stray;
    bit   ir_pending;
    logic [31:0] ir_exp;
    exp_t e;
    cyc = 0; mem_cyc = 0; md_cnt = 0; irwe_cnt = 0; rf_stray = 0;
    ir_pending = 1'b0; ir_exp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_strobes", {24'd0, imem_req, ir_we, md_start, dmem_req,
                                dmem_we, rf_we, pc_we, pc_sel}, 32'd0);
        if (rst_seen) begin
          check("reset_state", {29'd0, state_o}, {29'd0, ST_FETCH});
          check("reset_instret", instret, 32'd0);
        end
        cyc = 0; mem_cyc = 0; md_cnt = 0; irwe_cnt = 0; rf_stray = 0;
        ir_pending = 1'b0;
      end else begin
        cyc++;
        if (ir_pending) begin
          check("instret", instret, ir_exp);
          ir_pending = 1'b0;
        end
        if (cyc == 1) check("fetch_req", {31'd0, imem_req}, 32'd1);
        if (ir_we) irwe_cnt++;
        if (md_start) md_cnt++;
        if (rf_we && !pc_we) rf_stray++;
        if (dmem_req) begin
          mem_cyc++;
          if (exp_q.size() > 0) check("dmem_we", {31'd0, dmem_we}, {31'd0, exp_q[0].dmem_we});
        end
        if (pc_we) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_wb: got pc_we=1, required no write-back (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            check("latency", cyc, e.lat);
            check("wb_state", {29'd0, state_o}, {29'd0, ST_WB});
            check("rf_we", {31'd0, rf_we}, {31'd0, e.rf_we});
            check("pc_sel", {31'd0, pc_sel}, {31'd0, e.pc_sel});
            check("mem_cycles", mem_cyc, e.mem_cycles);
            check("md_pulses", md_cnt, e.md_pulses);
            check("ir_we_pulses", irwe_cnt, 32'd1);
            check("rf_we_outside_wb", rf_stray, 32'd0);
            ir_exp     = e.instret;
            ir_pending = 1'b1;
          end
          cyc = 0; mem_cyc = 0; md_cnt = 0; irwe_cnt = 0; rf_stray = 0;
        end
      end
    end
  end

  // Called at posedge+1 of the first FETCH cycle; returns at posedge+1 of the next FETCH.
  task automatic issue(input logic [3:0] op, input logic rw, rd, wr, br, tk,
                       input int unsigned a, d, k, input bit preload);
    int n;
    dec_alu_ops = op; dec_reg_write = rw; dec_mem_read = rd;
    dec_mem_write = wr; dec_is_branch = br; branch_taken = tk;
    cur_a = a; cur_d = d; cur_k = k;
    if (preload) model_ir = 32'hFFFF_FFFF;
    model_ir = model_ir + 32'd1;
    exp_q.push_back(model(op, rw, rd, wr, br, tk, a, d, k, model_ir));
    if (preload) begin
      @(negedge clk);
      #1 force dut.instret_reg = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 release dut.instret_reg;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (pc_we) break;
      n++;
      if (n > 300) begin
        fails++;
        $display("FAIL wb_timeout: got no pc_we in 300 cycles, required write-back");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "write-back timeout");
      end
    end
    tick();
  endtask

  // Starts a long LW or MUL, then pulls rst while it is stalled in MEM or MD_WAIT.
  task automatic abort_in(input bit use_mem);
    int n;
    dec_reg_write = 1'b1; dec_mem_read = use_mem; dec_mem_write = 1'b0;
    dec_is_branch = 1'b0; branch_taken = 1'b0;
    dec_alu_ops = use_mem ? 4'h0 : ALU_MUL;
    cur_a = 0; cur_d = 40; cur_k = 40;
    n = 0;
    forever begin
      @(negedge clk);
      if (use_mem ? dmem_req : md_start) break;
      n++;
      if (n > 20) begin
        fails++;
        $display("FAIL abort_setup: got no stall state in 20 cycles, required MEM/MD_WAIT");
        break;
      end
    end
    tick(); tick(); tick();
    rst = 1'b1;
    model_ir = '0;
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, required completion before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [3:0] op;
    rst = 1'b1;
    dec_reg_write = 1'b0; dec_mem_read = 1'b0; dec_mem_write = 1'b0;
    dec_is_branch = 1'b0; dec_alu_ops = 4'h0; branch_taken = 1'b0;
    repeat (4) tick();
    rst = 1'b0;

    abort_in(1'b1);
    abort_in(1'b0);

    issue(4'h0,    1, 0, 0, 0, 0, 0, 0, 1, 0);  // ADD, immediate ack
    issue(4'h0,    1, 1, 0, 0, 0, 0, 3, 1, 0);  // LW, dmem_ack 3 cycles late
    stray_en = 1'b1;
    issue(ALU_MUL, 1, 0, 0, 0, 0, 0, 0, 6, 0);  // MUL, stray md_done in FETCH
    stray_en = 1'b0;
    issue(4'h1,    0, 0, 0, 1, 1, 1, 0, 1, 0);  // BEQ taken
    issue(4'h1,    0, 0, 0, 1, 0, 0, 0, 1, 0);  // BNE not taken
    issue(4'h0,    1, 1, 1, 0, 0, 0, 1, 1, 0);  // SW with read and write set
    issue(4'h0,    1, 0, 0, 0, 0, 0, 0, 1, 1);  // ADD with instret at 0xFFFF_FFFF
    issue(ALU_DIV, 1, 0, 0, 1, 1, 0, 0, 1, 0);  // DIV op on a branch: no MUL/DIV

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        op = ($urandom_range(0, 1) == 1) ? ALU_MUL : ALU_DIV;
      else
        op = 4'($urandom_range(0, 15));
      stray_en = ($urandom_range(0, 1) == 1);
      issue(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(0, 4), $urandom_range(1, 7), 1'b0);
    end
    tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
